// File: rtl/vga_bouncer.sv
// vga_bouncer: bouncing-box pattern generator for the 640x480 VGA path.
//
// A white border frame is drawn around the visible area. One solid box moves
// once per frame and reflects off the inside of the border. Each bounce
// advances the box colour through an 8-entry RGB332 palette, pulses the
// bounce/corner outputs and bumps a saturating bounce counter.
//
// Ports:
//   clk25      in   25 MHz pixel clock
//   clr        in   asynchronous active-high reset
//   vidon      in   visible-region flag from the sync block
//   vsync      in   vertical sync; its rising edge is the frame tick
//   hc, vc     in   horizontal / vertical counters (10 bit)
//   pause      in   1 = freeze motion
//   step       in   one-cycle pulse, one motion update while paused
//   dx, dy     in   per-axis speed in pixels/frame, sampled at update
//   red/green/blue out  registered RGB332 pixel, 1 cycle after hc/vc/vidon
//   bounce     out  one-cycle pulse on any wall hit
//   corner     out  one-cycle pulse when both axes hit in the same update
//   bounce_cnt out  saturating count of updates that had a hit
module vga_bouncer #(
  parameter int HBP   = 144,
  parameter int HFP   = 784,
  parameter int VBP   = 31,
  parameter int VFP   = 511,
  parameter int BW    = 4,
  parameter int BOX_W = 32,
  parameter int BOX_H = 24,
  parameter int X0    = 149,
  parameter int Y0    = 36
) (
  input  logic        clk25,
  input  logic        clr,
  input  logic        vidon,
  input  logic        vsync,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic        pause,
  input  logic        step,
  input  logic [2:0]  dx,
  input  logic [2:0]  dy,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        bounce,
  output logic        corner,
  output logic [15:0] bounce_cnt
);

  // Limits of the box's top-left corner; 11 bits so x+dx never wraps.
  localparam logic [10:0] XMIN = 11'(HBP + BW);
  localparam logic [10:0] XMAX = 11'(HFP - BW - BOX_W);
  localparam logic [10:0] YMIN = 11'(VBP + BW);
  localparam logic [10:0] YMAX = 11'(VFP - BW - BOX_H);

  // Border bands: [start, end) on each side.
  localparam logic [10:0] HB_LO = 11'(HBP);
  localparam logic [10:0] HB_HI = 11'(HBP + BW);
  localparam logic [10:0] HF_LO = 11'(HFP - BW);
  localparam logic [10:0] HF_HI = 11'(HFP);
  localparam logic [10:0] VB_LO = 11'(VBP);
  localparam logic [10:0] VB_HI = 11'(VBP + BW);
  localparam logic [10:0] VF_LO = 11'(VFP - BW);
  localparam logic [10:0] VF_HI = 11'(VFP);

  localparam logic [10:0] BOX_WM1 = 11'(BOX_W - 1);
  localparam logic [10:0] BOX_HM1 = 11'(BOX_H - 1);
  localparam logic [9:0]  X_RST   = 10'(X0);
  localparam logic [9:0]  Y_RST   = 10'(Y0);

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_t;

  // One axis of motion. dir=1 moves towards hi. A zero speed holds
  // everything, so a box parked on a wall does not re-trigger a hit.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic dir,
                                      input logic [2:0] d,
                                      input logic [10:0] lo, input logic [10:0] hi);
    axis_t      r;
    logic [10:0] p11;
    logic [10:0] d11;
    p11   = {1'b0, pos};
    d11   = {8'b0, d};
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (d != 3'd0) begin
      if (dir) begin
        if (p11 + d11 >= hi) begin
          r.pos = hi[9:0];
          r.dir = 1'b0;
          r.hit = 1'b1;
        end else begin
          r.pos = pos + {7'b0, d};
        end
      end else begin
        // Landing exactly on the wall counts as a hit too.
        if ((p11 < lo + d11) || (p11 - d11 == lo)) begin
          r.pos = lo[9:0];
          r.dir = 1'b1;
          r.hit = 1'b1;
        end else begin
          r.pos = pos - {7'b0, d};
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] palette(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'hE0;
      3'd1:    c = 8'h1C;
      3'd2:    c = 8'h03;
      3'd3:    c = 8'hFC;
      3'd4:    c = 8'hE3;
      3'd5:    c = 8'h1F;
      3'd6:    c = 8'hFF;
      default: c = 8'hF0;
    endcase
    return c;
  endfunction

  logic        vs_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        xdir_q, xdir_d, ydir_q, ydir_d;
  logic [2:0]  col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bounce_q, corner_q;
  logic [7:0]  rgb_q, rgb_d;
  logic        tick, upd, hitx, hity, hit;
  axis_t       ax, ay;

  // Frame tick from the vsync rising edge; vs_q resets high so the first
  // cycle after reset never ticks.
  assign tick = vsync & ~vs_q;
  // Ticks drive motion when running; step drives it only when paused.
  assign upd  = (tick & ~pause) | (step & pause);

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    xdir_d = xdir_q;
    ydir_d = ydir_q;
    hitx   = 1'b0;
    hity   = 1'b0;
    ax     = axis_step(x_q, xdir_q, dx, XMIN, XMAX);
    ay     = axis_step(y_q, ydir_q, dy, YMIN, YMAX);
    if (upd) begin
      x_d    = ax.pos;
      xdir_d = ax.dir;
      hitx   = ax.hit;
      y_d    = ay.pos;
      ydir_d = ay.dir;
      hity   = ay.hit;
    end
    hit   = hitx | hity;
    col_d = hit ? col_q + 3'd1 : col_q;
    cnt_d = (hit && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  // Pixel colour, priority: blanking, border, box, background.
  logic [10:0] hc11, vc11, bx11, by11;
  logic        in_border, in_box;

  always_comb begin
    hc11      = {1'b0, hc};
    vc11      = {1'b0, vc};
    bx11      = {1'b0, x_q};
    by11      = {1'b0, y_q};
    in_border = ((hc11 >= HB_LO) && (hc11 < HB_HI)) ||
                ((hc11 >= HF_LO) && (hc11 < HF_HI)) ||
                ((vc11 >= VB_LO) && (vc11 < VB_HI)) ||
                ((vc11 >= VF_LO) && (vc11 < VF_HI));
    in_box    = (hc11 >= bx11) && (hc11 <= bx11 + BOX_WM1) &&
                (vc11 >= by11) && (vc11 <= by11 + BOX_HM1);
    rgb_d     = 8'h00;
    if (vidon) begin
      if (in_border) rgb_d = 8'hFF;
      else if (in_box) rgb_d = palette(col_q);
    end
  end

  always_ff @(posedge clk25 or posedge clr) begin
    if (clr) begin
      vs_q     <= 1'b1;
      x_q      <= X_RST;
      y_q      <= Y_RST;
      xdir_q   <= 1'b1;
      ydir_q   <= 1'b1;
      col_q    <= 3'd0;
      cnt_q    <= 16'd0;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      rgb_q    <= 8'h00;
    end else begin
      vs_q     <= vsync;
      x_q      <= x_d;
      y_q      <= y_d;
      xdir_q   <= xdir_d;
      ydir_q   <= ydir_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      bounce_q <= hit;
      corner_q <= hitx & hity;
      rgb_q    <= rgb_d;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign bounce             = bounce_q;
  assign corner             = corner_q;
  assign bounce_cnt         = cnt_q;

endmodule

// File: tb/tb_vga_bouncer.sv
// Testbench for vga_bouncer: drives frame ticks / steps and pixel probes,
// comparing against a behavioural model of box position, direction, colour
// and bounce count kept in plain integers.
module tb_vga_bouncer;
  localparam int HBP = 144, HFP = 784, VBP = 31, VFP = 511, BW = 4;
  localparam int BOX_W = 32, BOX_H = 24, X0 = 149, Y0 = 36;
  localparam int XMIN = HBP + BW, XMAX = HFP - BW - BOX_W;
  localparam int YMIN = VBP + BW, YMAX = VFP - BW - BOX_H;

  logic        clk25 = 1'b0;
  logic        clr, vidon, vsync, pause, step;
  logic [9:0]  hc, vc;
  logic [2:0]  dx, dy;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        bounce, corner;
  logic [15:0] bounce_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int m_x, m_y, m_xdir, m_ydir, m_col, m_cnt;
  logic [7:0] pal [8] = '{8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'hFF, 8'hF0};
  logic [7:0] exp_q [$];

  vga_bouncer dut (
    .clk25(clk25), .clr(clr), .vidon(vidon), .vsync(vsync),
    .hc(hc), .vc(vc), .pause(pause), .step(step), .dx(dx), .dy(dy),
    .red(red), .green(green), .blue(blue),
    .bounce(bounce), .corner(corner), .bounce_cnt(bounce_cnt)
  );

  // ---------------- clock ----------------
  always #20 clk25 = ~clk25;

  // ---------------- model ----------------
  task automatic model_reset();
    m_x = X0; m_y = Y0; m_xdir = 1; m_ydir = 1; m_col = 0; m_cnt = 0;
  endtask

  task automatic model_axis(inout int p, inout int dir, input int d,
                            input int lo, input int hi, output bit hit);
    hit = 0;
    if (d == 0) return;
    if (dir == 1) begin
      if (p + d >= hi) begin p = hi; dir = 0; hit = 1; end
      else p = p + d;
    end else begin
      if (p - d <= lo) begin p = lo; dir = 1; hit = 1; end
      else p = p - d;
    end
  endtask

  function automatic logic [7:0] model_pixel(input int h, input int v, input bit vid);
    if (!vid) return 8'h00;
    if ((h >= HBP && h < HBP + BW) || (h >= HFP - BW && h < HFP) ||
        (v >= VBP && v < VBP + BW) || (v >= VFP - BW && v < VFP)) return 8'hFF;
    if (h >= m_x && h < m_x + BOX_W && v >= m_y && v < m_y + BOX_H) return pal[m_col];
    return 8'h00;
  endfunction

  // ---------------- drivers ----------------
  // One cycle with optional vsync rise / step pulse, then one quiet cycle.
  task automatic do_update_cycle(input bit use_tick, input bit use_step);
    bit hx, hy, will;
    @(negedge clk25);
    vsync = use_tick;
    step  = use_step;
    @(posedge clk25);
    #1;
    will = (use_tick && !pause) || (use_step && pause);
    hx = 0; hy = 0;
    if (will) begin
      model_axis(m_x, m_xdir, int'(dx), XMIN, XMAX, hx);
      model_axis(m_y, m_ydir, int'(dy), YMIN, YMAX, hy);
    end
    if (hx || hy) begin
      m_col = (m_col + 1) % 8;
      if (m_cnt < 65535) m_cnt++;
    end
    checks++;
    if (bounce !== (hx | hy)) begin
      errors++; $display("FAIL bounce_pulse: got %b want %b", bounce, hx | hy);
    end
    checks++;
    if (corner !== (hx & hy)) begin
      errors++; $display("FAIL corner_pulse: got %b want %b", corner, hx & hy);
    end
    checks++;
    if (bounce_cnt !== 16'(m_cnt)) begin
      errors++; $display("FAIL bounce_cnt: got %0d want %0d", bounce_cnt, m_cnt);
    end
    @(negedge clk25);
    vsync = 1'b0;
    step  = 1'b0;
    @(posedge clk25);
    #1;
    checks++;
    if (bounce !== 1'b0 || corner !== 1'b0) begin
      errors++; $display("FAIL pulse_width: bounce=%b corner=%b want 0 0", bounce, corner);
    end
  endtask

  task automatic probe(input int h, input int v, input bit vid);
    logic [7:0] got, want;
    @(negedge clk25);
    hc = 10'(h); vc = 10'(v); vidon = vid;
    exp_q.push_back(model_pixel(h, v, vid));
    @(posedge clk25);
    #1;
    got  = {red, green, blue};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL pixel(%0d,%0d,%0b): got %h want %h", h, v, vid, got, want);
    end
  endtask

  // Probes just inside and just outside each edge of the model's box.
  task automatic probe_box();
    probe(m_x, m_y, 1);
    probe(m_x - 1, m_y, 1);
    probe(m_x + BOX_W - 1, m_y + BOX_H - 1, 1);
    probe(m_x + BOX_W, m_y, 1);
    probe(m_x, m_y + BOX_H, 1);
    probe(m_x, m_y - 1, 1);
  endtask

  // Walk one axis (other held at speed 0) until it sits at target moving forward.
  task automatic move_to(input bit is_y, input int target);
    int guard = 0;
    int p, d;
    while (guard < 400) begin
      p = is_y ? m_y : m_x;
      d = is_y ? m_ydir : m_xdir;
      if (d == 1 && p == target) break;
      if (d == 1 && target > p && target - p <= 7) begin
        if (is_y) dy = 3'(target - p); else dx = 3'(target - p);
      end else begin
        if (is_y) dy = 3'd7; else dx = 3'd7;
      end
      if (is_y) dx = 3'd0; else dy = 3'd0;
      do_update_cycle(1, 0);
      guard++;
    end
    if (guard >= 400) begin
      errors++; $display("FAIL move_to: axis %0d did not reach %0d", is_y, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1; vsync = 1; vidon = 1; hc = 10'(HBP); vc = 10'd100;
    pause = 0; step = 0; dx = 3'd3; dy = 3'd2;
    repeat (3) @(posedge clk25);
    #1;
    checks++;
    if ({red, green, blue} !== 8'h00) begin
      errors++; $display("FAIL reset_rgb: got %h want 00", {red, green, blue});
    end
    checks++;
    if (bounce !== 1'b0 || corner !== 1'b0 || bounce_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_evt: got %b %b %0d want 0 0 0", bounce, corner, bounce_cnt);
    end
    // Release with vsync already high: must not count as a frame tick.
    @(negedge clk25);
    clr = 0;
    @(negedge clk25);
    vsync = 0;
    @(posedge clk25);
    #1;
    checks++;
    if (bounce !== 1'b0) begin
      errors++; $display("FAIL reset_no_tick: bounce got %b want 0", bounce);
    end
    model_reset();
    probe_box();
  endtask

  task automatic test_motion();
    pause = 0; dx = 3'd3; dy = 3'd2;
    repeat (10) do_update_cycle(1, 0);
    probe(179, 56, 1);
    probe(148, 56, 1);
    probe(179, 56, 0);
    probe_box();
  endtask

  task automatic test_right_wall();
    pause = 0;
    move_to(0, 745);
    dx = 3'd5; dy = 3'd0;
    do_update_cycle(1, 0);   // hits the right wall
    probe_box();
    do_update_cycle(1, 0);   // moving back left
    probe_box();
  endtask

  task automatic test_left_exact();
    pause = 0; dy = 3'd0; dx = 3'd7;
    while (m_xdir == 0 && m_x - 7 > XMIN) do_update_cycle(1, 0);
    if (m_xdir == 0) begin
      dx = 3'(m_x - XMIN);   // lands exactly on the left wall
      do_update_cycle(1, 0);
    end
    probe_box();
  endtask

  task automatic test_corner();
    pause = 0;
    move_to(0, XMAX - 1);
    move_to(1, YMAX - 1);
    dx = 3'd1; dy = 3'd1;
    do_update_cycle(1, 0);
    probe_box();
    // Speed zero while parked on the wall: no hit.
    dx = 3'd0; dy = 3'd0;
    do_update_cycle(1, 0);
    probe_box();
  endtask

  task automatic test_pause_step();
    dx = 3'd2; dy = 3'd3;
    pause = 1;
    repeat (5) do_update_cycle(1, 0);
    probe_box();
    do_update_cycle(0, 1);
    probe_box();
    do_update_cycle(1, 1);
    probe_box();
    pause = 0;
    do_update_cycle(0, 1);
    probe_box();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      pause = 1'($urandom_range(0, 1));
      dx    = 3'($urandom_range(0, 7));
      dy    = 3'($urandom_range(0, 7));
      do_update_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (i % 10 == 0) probe_box();
      if (i % 7 == 0) probe($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 1)));
    end
    pause = 0;
  endtask

  task automatic test_clr_mid();
    probe(HFP - 1, 200, 1);
    @(negedge clk25);
    #5 clr = 1;
    #1;
    checks++;
    if ({red, green, blue} !== 8'h00 || bounce_cnt !== 16'd0) begin
      errors++; $display("FAIL clr_async: rgb %h cnt %0d want 00 0", {red, green, blue}, bounce_cnt);
    end
    @(posedge clk25);
    #1;
    checks++;
    if ({red, green, blue} !== 8'h00) begin
      errors++; $display("FAIL clr_edge_rgb: got %h want 00", {red, green, blue});
    end
    @(negedge clk25);
    clr = 0;
    model_reset();
    probe_box();
  endtask

  initial begin
    test_reset();
    test_motion();
    test_right_wall();
    test_left_exact();
    test_corner();
    test_pause_step();
    test_random();
    test_clr_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
